// File: rtl/rvvi_tx_arbiter_pkg.sv
// rvvi_tx_arbiter_pkg: shared types for the RVVI transmit arbiter
//   state_t    : which source the packet in the output register came from (IDLE = none held)
//   src_t      : which source is granted in the current cycle
//   held_state : the state a given grant leaves the output register in
package rvvi_tx_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, SEND_NEW, SEND_REPLAY} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_NEW, SRC_REPLAY} src_t;
   function automatic state_t held_state(src_t s);
      return s == SRC_NEW ? SEND_NEW : s == SRC_REPLAY ? SEND_REPLAY : IDLE;
   endfunction
endpackage

// File: rtl/rvvi_ack_timer.sv
// rvvi_ack_timer: ack watchdog that requests an active-list replay after TIMEOUT silent cycles
//   clk, reset  : clock, asynchronous active-high reset
//   AckValid    : ack seen this cycle (restarts the count, beats a same-cycle expiry)
//   Outstanding : active list non-empty; the count only runs while this is high
//   Suppress    : a replay is already available or being sent, so no new request
//   ReplayReq   : one-cycle replay request pulse
module rvvi_ack_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic AckValid,
   input  logic Outstanding,
   input  logic Suppress,
   output logic ReplayReq
);
   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   logic [W-1:0] cnt;
   // The count parks at LAST while suppressed so the request fires as soon as suppression lifts.
   assign ReplayReq = cnt == LAST && Outstanding && !AckValid && !Suppress;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (AckValid || !Outstanding || ReplayReq) ? '0 : cnt == LAST ? cnt : cnt + 1'b1;
endmodule

// File: rtl/rvvi_tx_arbiter.sv
// rvvi_tx_arbiter: picks new or replayed RVVI packets into a one-deep output register for the MAC
//   clk, reset                  : clock, asynchronous active-high reset
//   NewValid/NewData/NewReady   : new packet source, NewReady = accepted this cycle
//   ReplayValid/ReplayData      : active-list replay source
//   ReplayStall                 : low only in the cycle the replay packet is accepted
//   AckValid/Outstanding        : ack and non-empty status from the active list
//   ReplayReq                   : timeout pulse asking the active list to replay
//   TxValid/TxData/TxReady      : registered packet handshake to the MAC
//   TxIsReplay                  : held packet came from the replay source
module rvvi_tx_arbiter
   import rvvi_tx_arbiter_pkg::*;
#(
   parameter int WIDTH    = 792,
   parameter int MAXBURST = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             NewValid,
   input  logic [WIDTH-1:0] NewData,
   output logic             NewReady,
   input  logic             ReplayValid,
   input  logic [WIDTH-1:0] ReplayData,
   output logic             ReplayStall,
   input  logic             AckValid,
   input  logic             Outstanding,
   output logic             ReplayReq,
   output logic             TxValid,
   output logic [WIDTH-1:0] TxData,
   input  logic             TxReady,
   output logic             TxIsReplay
);
   localparam int BW = $clog2(MAXBURST + 1);
   localparam logic [BW-1:0] BMAX = BW'(MAXBURST);
   state_t state, state_nxt;
   src_t sel;
   logic slot_free;
   logic [BW-1:0] burst;
   assign slot_free = state == IDLE || TxReady;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   // Replay wins until MAXBURST replays have gone out while a new packet waited.
   always_comb begin
      sel = !slot_free ? SRC_NONE
          : (ReplayValid && burst < BMAX) ? SRC_REPLAY
          : NewValid ? SRC_NEW
          : ReplayValid ? SRC_REPLAY : SRC_NONE;
      state_nxt = slot_free ? held_state(sel) : state;
   end
   always_comb begin
      TxValid     = state != IDLE;
      TxIsReplay  = state == SEND_REPLAY;
      NewReady    = !reset && sel == SRC_NEW;
      ReplayStall = reset || sel != SRC_REPLAY;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         TxData <= '0;
         burst  <= '0;
      end else begin
         TxData <= sel == SRC_NEW ? NewData : sel == SRC_REPLAY ? ReplayData : TxData;
         burst  <= sel == SRC_NEW ? '0
                 : (sel == SRC_REPLAY && NewValid && burst < BMAX) ? burst + 1'b1 : burst;
      end
   rvvi_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .AckValid    (AckValid),
      .Outstanding (Outstanding),
      .Suppress    (ReplayValid || state == SEND_REPLAY),
      .ReplayReq   (ReplayReq)
   );
endmodule
